// File: rtl/keypad_entry_reg.sv
// Keypad entry register: turns raw keypad codes into four BCD key digits and flags a complete entry.
// Optional build macro KEY_RANGE_CHECK_EN restricts key_valid to entries that form a legal HH:MM time.
module keypad_entry_reg #(
    parameter int         TIMEOUT_SEC = 10,
    parameter logic [3:0] NO_KEY      = 4'd10
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       one_second,
    input  logic [3:0] key,
    input  logic       clear_keys,
    output logic [3:0] key_ms_hr,
    output logic [3:0] key_ls_hr,
    output logic [3:0] key_ms_min,
    output logic [3:0] key_ls_min,
    output logic       key_pressed,
    output logic       key_valid,
    output logic       timeout
);

    localparam int             CW        = $clog2(TIMEOUT_SEC + 1);
    localparam logic [CW-1:0]  SEC_LAST  = CW'(TIMEOUT_SEC - 1);
    localparam logic [CW-1:0]  SEC_ONE   = CW'(1);
    localparam logic [CW-1:0]  SEC_ZERO  = CW'(0);
    localparam logic [3:0]     DIGIT_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state_r;
    logic [2:0]      count_r;
    logic [CW-1:0]   sec_cnt_r;
    logic [3:0]      key_prev_r;
    logic [3:0]      ms_hr_r;
    logic [3:0]      ls_hr_r;
    logic [3:0]      ms_min_r;
    logic [3:0]      ls_min_r;
    logic            key_pressed_r;
    logic            timeout_r;
    logic            press_s;
    logic            expire_s;
    logic            range_ok_s;
    logic            key_valid_s;

`ifdef KEY_RANGE_CHECK_EN
    function automatic logic entry_in_range(input logic [3:0] mh, input logic [3:0] lh,
                                            input logic [3:0] mm, input logic [3:0] lm);
        logic hr_ok;
        if (mh == 4'd2) begin
            hr_ok = (lh <= 4'd3);
        end else begin
            hr_ok = (lh <= 4'd9);
        end
        return (mh <= 4'd2) && hr_ok && (mm <= 4'd5) && (lm <= 4'd9);
    endfunction

    assign range_ok_s = entry_in_range(ms_hr_r, ls_hr_r, ms_min_r, ls_min_r);
`else
    assign range_ok_s = 1'b1;
`endif

    // Any code above 9 counts as idle, so only a digit following an idle code is a new press.
    assign press_s  = (key <= DIGIT_MAX) && (key_prev_r > DIGIT_MAX);
    assign expire_s = (state_r != IDLE) && one_second && (sec_cnt_r == SEC_LAST);

    // key_valid is a decode of the registered digits and state.
    always_comb begin
        key_valid_s = 1'b0;
        if (state_r == FULL) begin
            key_valid_s = range_ok_s;
        end else begin
            key_valid_s = 1'b0;
        end
    end

    // Entry state machine: clear beats press, press beats inactivity expiry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            count_r       <= 3'd0;
            sec_cnt_r     <= SEC_ZERO;
            key_prev_r    <= NO_KEY;
            ms_hr_r       <= 4'd0;
            ls_hr_r       <= 4'd0;
            ms_min_r      <= 4'd0;
            ls_min_r      <= 4'd0;
            key_pressed_r <= 1'b0;
            timeout_r     <= 1'b0;
        end else begin
            key_prev_r    <= key;
            key_pressed_r <= 1'b0;
            timeout_r     <= 1'b0;
            if (clear_keys || expire_s) begin
                state_r   <= IDLE;
                count_r   <= 3'd0;
                sec_cnt_r <= SEC_ZERO;
                ms_hr_r   <= 4'd0;
                ls_hr_r   <= 4'd0;
                ms_min_r  <= 4'd0;
                ls_min_r  <= 4'd0;
                // A press in the expiry cycle takes precedence over the expiry.
                if (!clear_keys && press_s) begin
                    state_r       <= (count_r >= 3'd3) ? FULL : ENTRY;
                    count_r       <= (count_r >= 3'd3) ? 3'd4 : count_r + 3'd1;
                    ms_hr_r       <= ls_hr_r;
                    ls_hr_r       <= ms_min_r;
                    ms_min_r      <= ls_min_r;
                    ls_min_r      <= key;
                    key_pressed_r <= 1'b1;
                end else begin
                    timeout_r <= !clear_keys;
                end
            end else if (press_s) begin
                state_r       <= (count_r >= 3'd3) ? FULL : ENTRY;
                count_r       <= (count_r >= 3'd3) ? 3'd4 : count_r + 3'd1;
                sec_cnt_r     <= SEC_ZERO;
                ms_hr_r       <= ls_hr_r;
                ls_hr_r       <= ms_min_r;
                ms_min_r      <= ls_min_r;
                ls_min_r      <= key;
                key_pressed_r <= 1'b1;
            end else begin
                case (state_r)
                    IDLE:    sec_cnt_r <= SEC_ZERO;
                    ENTRY,
                    FULL:    sec_cnt_r <= one_second ? (sec_cnt_r + SEC_ONE) : sec_cnt_r;
                    default: begin
                        state_r   <= IDLE;
                        sec_cnt_r <= SEC_ZERO;
                    end
                endcase
            end
        end
    end

    assign key_ms_hr   = ms_hr_r;
    assign key_ls_hr   = ls_hr_r;
    assign key_ms_min  = ms_min_r;
    assign key_ls_min  = ls_min_r;
    assign key_pressed = key_pressed_r;
    assign key_valid   = key_valid_s;
    assign timeout     = timeout_r;

endmodule
